dem_nbit_mod: RTL
=================

Name: dem_nbit_mod

Overview:
- Parametrised successor of the 8-bit up/down counter with start/stop.
- Adds:
  - generic width;
  - programmable modulo limit;
  - wrap or saturate mode;
  - synchronous load;
  - built-in clock-enable prescaler;
  - terminal-count pulse and sticky overflow flag.
- Used as the general counter/timer primitive in the counter designs.
- Feeds display/decode logic through `out` and sequencing logic through `tc`.

Parameters:
- WIDTH, 8, counter width in bits (WIDTH >= 2).
- PRESCALE, 1, clock cycles per count step while running (PRESCALE >= 1; 1 = step every enabled cycle).
- PS_W, $clog2(PRESCALE)+1, prescaler register width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- SS  in  1  start/stop: 1 = run, 0 = hold count and prescaler.
- UD  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value captured on load.
- max_val  in  WIDTH  upper count limit (range 0..max_val); sampled every cycle.
- mode  in  1  0 = wrap, 1 = saturate.
- clr_ovf  in  1  clears the sticky ovf flag.
- out  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse, one cycle.
- ovf  out  1  sticky boundary-event flag.
- zero  out  1  out == 0 (combinational from the out register).

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: out = 0, tc = 0, ovf = 0, prescaler = 0.
  - reset overrides every other input in the same cycle.
- Priority per cycle: reset > load > step > hold.
- Load:
  - out <= min(load_val, max_val); prescaler <= 0; tc <= 0.
  - ovf unaffected.
  - Load is honoured regardless of SS.
- Prescaler:
  - While SS=1 and no load: ps counts 0..PRESCALE-1 and wraps.
  - step_en = SS & (ps == PRESCALE-1).
  - With PRESCALE=1, step_en = SS.
  - SS=0: ps holds its value; resuming continues the partial period.
- Step (step_en=1), UD=1:
  - out < max_val: out+1.
  - out >= max_val: boundary event. Wrap: out <= 0. Saturate: out <= max_val.
- Step, UD=0:
  - 0 < out <= max_val: out-1.
  - out == 0: boundary event. Wrap: out <= max_val. Saturate: out stays 0.
  - out > max_val (max_val lowered while running): out <= max_val, no event.
- Boundary event:
  - tc = 1 in the cycle out shows the post-event value; tc = 0 otherwise.
  - Saturated holds assert tc on every step attempt.
  - ovf <= 1.
- ovf:
  - Cleared by clr_ovf=1.
  - If clr_ovf and a boundary event occur in the same cycle, set wins (ovf = 1).
- max_val = 0: out stays 0.
  - Every step is a boundary event (tc each step_en, ovf set).
- No arithmetic overflow beyond WIDTH.
  - Compares and increments are done at WIDTH bits.
  - max_val = 2^WIDTH-1 gives the full natural range.
- UD and mode changes take effect on the next step; no pipeline.
- Step latency: out updates one clock after the edge where step_en is sampled high.
- Reset mid-run discards the prescaler phase.

Decomposition:
- Package dem_pkg holds MODE_WRAP = 1'b0, MODE_SAT = 1'b1, DIR_UP = 1'b1, DIR_DN = 1'b0.
- Sub-module dem_prescaler(clk, reset, run, clr, tick), parametrised by PRESCALE.
  - Owns ps.
  - Top instantiates it with run=SS&~load and clr=load.
- Top holds the count/flag logic.

Test Plan:
- Reset/hold: WIDTH=8, PRESCALE=1. reset=1 for 3 cycles, then reset=0, SS=0 for 5 cycles -> out=0, tc=0, ovf=0, zero=1 throughout.
- Wrap up: max_val=9, mode=0, UD=1, SS=1 for 12 cycles -> out 1..9, 0, 1, 2. tc high only with out=0. ovf=1 afterwards. clr_ovf pulse -> ovf=0.
- Wrap down and saturate:
  - Load 2, UD=0, mode=0, max_val=9 -> out 1, 0, 9, 8, with tc at 9.
  - Then load 1, mode=1 -> out 0, 0, 0, with tc high on each step after reaching 0.
- Prescaler: PRESCALE=4, max_val=255, UD=1.
  - SS=1 for 8 cycles -> out 0→1→2, one step every 4th cycle.
  - SS=0 for 2 cycles mid-period -> phase held; next step exactly when the remaining count completes.
- Load clamp/priority:
  - load_val=200, max_val=100 -> out=100.
  - load=1 with SS=1 step due -> load wins, no step.
  - reset=1 with load=1 -> out=0.
- Limit lowered: out=50 counting, max_val changed to 20.
  - UD=0 -> out=20, no tc.
  - UD=1, mode=1 -> out=20, tc=1, ovf=1.

Source files
------------

// File: rtl/dem_pkg.sv
// Shared constants for the dem_nbit_mod counter family.
// Mode and direction encodings used by the counter and its users.
package dem_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;

endpackage

// File: rtl/dem_prescaler.sv
// Clock-enable prescaler: asserts tick on the last cycle of each PRESCALE-cycle period.
// The phase holds while run is low, so a paused period resumes where it stopped.
module dem_prescaler #(
  parameter int PRESCALE = 1,
  parameter int PS_W     = $clog2(PRESCALE) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_r;

  assign tick = run & (ps_r == PS_LAST);

  // Phase counter: cleared by reset or load, advances only while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_r <= PS_ZERO;
    end else if (clr) begin
      ps_r <= PS_ZERO;
    end else if (run) begin
      if (ps_r == PS_LAST) begin
        ps_r <= PS_ZERO;
      end else begin
        ps_r <= ps_r + PS_ONE;
      end
    end else begin
      ps_r <= ps_r;
    end
  end

endmodule

// File: rtl/dem_nbit_mod.sv
// Parametrised up/down modulo counter with load, prescaler, wrap/saturate modes,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module dem_nbit_mod
  import dem_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int PS_W     = $clog2(PRESCALE) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SS,
  input  logic             UD,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] out_r, out_next_s;
  logic             tc_r, ovf_r;
  logic             step_en_s, event_s;

  dem_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (SS & ~load),
    .clr   (load),
    .tick  (step_en_s)
  );

  // Next-count and boundary-event decode; load beats step, step beats hold.
  always_comb begin
    out_next_s = out_r;
    event_s    = 1'b0;
    if (load) begin
      out_next_s = (load_val > max_val) ? max_val : load_val;
    end else if (step_en_s) begin
      case (UD)
        DIR_UP: begin
          if (out_r < max_val) begin
            out_next_s = out_r + CNT_ONE;
          end else begin
            event_s    = 1'b1;
            out_next_s = (mode == MODE_SAT) ? max_val : CNT_ZERO;
          end
        end
        DIR_DN: begin
          if (out_r == CNT_ZERO) begin
            event_s    = 1'b1;
            out_next_s = (mode == MODE_SAT) ? CNT_ZERO : max_val;
          end else if (out_r > max_val) begin
            // Limit was lowered under a running count: snap down without an event.
            out_next_s = max_val;
          end else begin
            out_next_s = out_r - CNT_ONE;
          end
        end
        default: begin
          out_next_s = out_r;
          event_s    = 1'b0;
        end
      endcase
    end else begin
      out_next_s = out_r;
      event_s    = 1'b0;
    end
  end

  // Count and flag registers; a boundary event beats a simultaneous clr_ovf.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= CNT_ZERO;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      out_r <= out_next_s;
      tc_r  <= event_s;
      if (event_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign out  = out_r;
  assign tc   = tc_r;
  assign ovf  = ovf_r;
  assign zero = (out_r == CNT_ZERO);

endmodule
